// File: rtl/mcac_pkg.sv
// Shared constants and types for the multi-channel ADPCM decoder scale-factor logic.
package mcac_pkg;

  localparam int unsigned YL_W = 19;
  localparam int unsigned YU_W = 13;

  localparam logic [YL_W-1:0] YL_INIT = 19'd34816;
  localparam logic [YU_W-1:0] YU_INIT = 13'd544;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WRITE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/filte.sv
// Slow scale-factor filter: YLP = YL + sext((YUP + ((2^20 - YL) >> 6)) mod 2^14).
module filte
  import mcac_pkg::*;
(
  input  logic [YU_W-1:0] yup,
  input  logic [YL_W-1:0] yl,
  output logic [YL_W-1:0] ylp
);

  localparam int unsigned SPAN_W = 21;
  localparam int unsigned DIF_W  = 14;

  logic [SPAN_W-1:0] span;
  logic [DIF_W-1:0]  dif;
  logic [YL_W-1:0]   difsx;

  always_comb begin
    span  = 21'd1048576 - SPAN_W'(yl);
    dif   = DIF_W'(SPAN_W'(yup) + (span >> 6));
    difsx = {{(YL_W - DIF_W){dif[DIF_W-1]}}, dif};
    ylp   = yl + difsx;
  end

endmodule

// File: rtl/sf_rr_arb.sv
// Round-robin arbiter: first request found searching upward from last+1, wrapping at NCH.
module sf_rr_arb #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] last,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] idx
);

  logic           found;
  logic [CHW-1:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    // k = NCH revisits 'last' itself, so a lone requester is never locked out
    for (int unsigned k = 1; k <= NCH; k++) begin
      pos = CHW'((32'(last) + k) % NCH);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/yl_adapt_sched.sv
// Time-shares one FILTE instance among NCH channels: holds per-channel YL,
// arbitrates round-robin and sequences read -> filter -> write-back.
module yl_adapt_sched
  import mcac_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NCH-1:0]      REQ,
  input  logic [NCH*YU_W-1:0] YUP_IN,
  input  logic                CLR_EN,
  input  logic [CHW-1:0]      CLR_ID,
  output logic [NCH-1:0]      ACK,
  output logic                YL_VALID,
  output logic [YL_W-1:0]     YL_OUT,
  output logic [CHW-1:0]      YL_CH
);

  sched_state_t state, state_n;
  logic         load, calc, wr;

  logic [YL_W-1:0] yl      [NCH];
  logic [YU_W-1:0] yup_arr [NCH];

  logic [CHW-1:0]  last, cur, arb_idx;
  logic [NCH-1:0]  cur_oh, arb_gnt;
  logic [YU_W-1:0] yup_r;
  logic [YL_W-1:0] ylp, ylp_r;
  logic            kill;
  logic            clr_hit;
  logic            clr_ok;

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign yup_arr[g] = YUP_IN[g*YU_W +: YU_W];
  end

  assign clr_hit = CLR_EN && (CLR_ID == cur);
  assign clr_ok  = CLR_EN && (32'(CLR_ID) < NCH);

  sf_rr_arb #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .req  (REQ),
    .last (last),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  filte u_filte (
    .yup (yup_r),
    .yl  (yl[cur]),
    .ylp (ylp)
  );

  // state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_n;
  end

  // next state and per-state strobes
  always_comb begin
    state_n = state;
    load    = 1'b0;
    calc    = 1'b0;
    wr      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|REQ) begin
          load    = 1'b1;
          state_n = ST_CALC;
        end
      end
      ST_CALC: begin
        calc    = 1'b1;
        state_n = ST_WRITE;
      end
      ST_WRITE: begin
        wr      = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // datapath, YL storage and registered outputs; a clear is assigned last so it wins
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NCH; i++) yl[i] <= YL_INIT;
      last     <= CHW'(NCH - 1);
      cur      <= '0;
      cur_oh   <= '0;
      yup_r    <= '0;
      ylp_r    <= '0;
      kill     <= 1'b0;
      ACK      <= '0;
      YL_VALID <= 1'b0;
      YL_OUT   <= '0;
      YL_CH    <= '0;
    end else begin
      ACK      <= '0;
      YL_VALID <= 1'b0;
      if (load) begin
        cur    <= arb_idx;
        cur_oh <= arb_gnt;
        yup_r  <= yup_arr[arb_idx];
      end
      if (calc) begin
        ylp_r <= ylp;
        kill  <= kill | clr_hit;
      end
      if (wr) begin
        if (!kill) yl[cur] <= ylp_r;
        ACK      <= cur_oh;
        YL_VALID <= 1'b1;
        YL_CH    <= cur;
        YL_OUT   <= (kill || clr_hit) ? YL_INIT : ylp_r;
        last     <= cur;
        kill     <= 1'b0;
      end
      if (clr_ok) yl[CLR_ID] <= YL_INIT;
    end
  end

endmodule

// File: tb/tb_yl_adapt_sched.sv
// Scoreboard bench for yl_adapt_sched: expected updates queued at issue, checked by a monitor.
module tb_yl_adapt_sched;
  import mcac_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req;
  logic [51:0]     yup_in;
  logic [12:0]     yup_v [4];
  logic            clr_en;
  logic [1:0]      clr_id;
  logic [3:0]      ack;
  logic            yl_valid;
  logic [18:0]     yl_out;
  logic [1:0]      yl_ch;

  typedef struct packed {
    logic [1:0]  ch;
    logic [18:0] yl;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  yl_adapt_sched #(.NCH(NCH), .CHW(CHW)) dut (
    .CLK      (clk),
    .RESET    (reset),
    .REQ      (req),
    .YUP_IN   (yup_in),
    .CLR_EN   (clr_en),
    .CLR_ID   (clr_id),
    .ACK      (ack),
    .YL_VALID (yl_valid),
    .YL_OUT   (yl_out),
    .YL_CH    (yl_ch)
  );

  always #5 clk = ~clk;

  always_comb yup_in = {yup_v[3], yup_v[2], yup_v[1], yup_v[0]};

  // requesters drop their line once they see their ACK
  always @(negedge clk) req = req & ~ack;

  // monitor: every presented update must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && (yl_valid || ack != 4'b0)) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_update: ack=%b valid=%b ch=%0d yl_out=%0d, none expected",
                 ack, yl_valid, yl_ch, yl_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (ack != (4'b0001 << mon_e.ch) || !yl_valid || yl_ch != mon_e.ch || yl_out != mon_e.yl) begin
          fails++;
          $display("FAIL update: ack=%b valid=%b ch=%0d yl_out=%0d, need ack=%b valid=1 ch=%0d yl_out=%0d",
                   ack, yl_valid, yl_ch, yl_out, 4'b0001 << mon_e.ch, mon_e.ch, mon_e.yl);
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, need %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic [18:0] yl);
    exp_t e;
    e.ch = ch;
    e.yl = yl;
    exp_q.push_back(e);
  endtask

  // single request from IDLE; clr_at: 0=IDLE, 1=CALC, 2=WRITE, -1=none
  task automatic run1(input logic [1:0] ch, input logic [12:0] yup, input logic [18:0] exp_yl,
                      input int clr_at, input logic [1:0] cid);
    int cyc;
    bit got;
    @(negedge clk);
    yup_v[ch] = yup;
    push(ch, exp_yl);
    req[ch] = 1'b1;
    clr_id  = cid;
    clr_en  = (clr_at == 0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      clr_en = (clr_at == cyc);
      if (ack[ch]) got = 1'b1;
    end
    clr_en = 1'b0;
    tests++;
    if (!got || cyc != 3) begin
      fails++;
      $display("FAIL latency_ch%0d: ack after %0d cycles (seen=%0d), need 3", ch, cyc, got);
    end
  endtask

  // wait for n back-to-back updates, each 3 cycles after the previous (or after issue)
  task automatic run_multi(input int n);
    int cyc;
    bit got;
    for (int k = 0; k < n; k++) begin
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 12) begin
        @(negedge clk);
        cyc++;
        if (ack != 4'b0) got = 1'b1;
      end
      tests++;
      if (!got || cyc != 3) begin
        fails++;
        $display("FAIL spacing_%0d: ack after %0d cycles (seen=%0d), need 3", k, cyc, got);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, need completion");
    $fatal(1);
  end

  initial begin
    bit seen;
    reset  = 1'b1;
    req    = 4'b0;
    clr_en = 1'b0;
    clr_id = 2'd0;
    for (int i = 0; i < 4; i++) yup_v[i] = 13'd0;
    repeat (3) @(negedge clk);
    check("reset_ack", ack, 0);
    check("reset_valid", yl_valid, 0);
    check("reset_yl_out", yl_out, 0);
    check("reset_yl_ch", yl_ch, 0);
    reset = 1'b0;

    // steady state, growth and decay from YL_INIT
    run1(2'd0, 13'd544, 19'd34816, -1, 2'd0);
    run1(2'd1, 13'd1088, 19'd35360, -1, 2'd0);
    run1(2'd2, 13'd0, 19'd34272, -1, 2'd0);

    // reset while channel 1 is in CALC: abort, no ACK
    @(negedge clk);
    yup_v[1] = 13'd1088;
    req[1]   = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b0;
    @(negedge clk);
    reset = 1'b0;
    check("post_reset_valid", yl_valid, 0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack != 4'b0) seen = 1'b1;
    end
    check("no_ack_after_abort", seen, 0);

    // round robin from fresh state: order 0,1,2,3, all YL back at YL_INIT
    @(negedge clk);
    yup_v[0] = 13'd544;
    yup_v[1] = 13'd1088;
    yup_v[2] = 13'd0;
    yup_v[3] = 13'd1088;
    push(2'd0, 19'd34816);
    push(2'd1, 19'd35360);
    push(2'd2, 19'd34272);
    push(2'd3, 19'd35360);
    req = 4'b1111;
    run_multi(4);

    // LAST = 3: channel 0 wins before channel 3
    @(negedge clk);
    yup_v[0] = 13'd544;
    yup_v[3] = 13'd1088;
    push(2'd0, 19'd34816);
    push(2'd3, 19'd35895);
    req = 4'b1001;
    run_multi(2);

    // clear of the in-flight channel during CALC
    run1(2'd2, 13'd1088, 19'd34816, 1, 2'd2);
    run1(2'd2, 13'd1088, 19'd35360, -1, 2'd0);

    // clear of another channel during WRITE leaves the write-back intact
    run1(2'd0, 13'd1088, 19'd35360, -1, 2'd0);
    run1(2'd1, 13'd544, 19'd35351, 2, 2'd0);
    run1(2'd1, 13'd544, 19'd35342, -1, 2'd0);
    run1(2'd0, 13'd544, 19'd34816, -1, 2'd0);

    // clear of the in-flight channel during WRITE
    run1(2'd3, 13'd544, 19'd34816, 2, 2'd3);
    run1(2'd3, 13'd1088, 19'd35360, -1, 2'd0);

    // clear in IDLE on the channel granted that same cycle
    run1(2'd1, 13'd1088, 19'd35360, 0, 2'd1);

    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
